// File: rtl/seg_display_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_display_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 32;

  typedef logic [SEG_W-1:0]    seg_t;
  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Active-low segment pattern with every segment dark.
  localparam seg_t SEG_ALL_OFF = 7'h7F;

  // Active-low anode pattern with every digit disabled (callers slice to NUM_DIGITS).
  localparam logic [MAX_DIGITS-1:0] ANODE_ALL_OFF = '1;

  // Anode pattern helper: all off, or only digit idx driven low.
  function automatic logic [MAX_DIGITS-1:0] anode_pattern(input logic on, input int unsigned idx);
    if (!on) return ANODE_ALL_OFF;
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/seven_segment.sv
// Hex nibble to active-low 7-segment decoder, segment [0]=a .. [6]=g.
module seven_segment
  import seg_display_pkg::*;
(
  input  nibble_t nibble,
  output seg_t    seg_c
);

  // Pure lookup; the caller registers the result.
  always_comb begin
    seg_c = SEG_ALL_OFF;
    unique case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = SEG_ALL_OFF;
    endcase
  end

endmodule

// File: rtl/seg_display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// New values are accepted over valid/ready and committed only at frame wrap.
module seg_display_scan_ctrl
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_W-1:0]     disp_data;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] disp_blank;
  logic [DATA_W-1:0]     pend_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pending;

  logic    slot_end_c;
  logic    last_digit_c;
  logic    wrap_c;
  logic    commit_c;
  logic    accept_c;
  logic    show_c;
  nibble_t cur_nibble_c;
  seg_t    dec_seg_c;

  // Scan and handshake decode from current state.
  always_comb begin
    slot_end_c   = (cnt == CNT_W'(REFRESH_CYCLES - 1));
    last_digit_c = (idx == IDX_W'(NUM_DIGITS - 1));
    wrap_c       = en && slot_end_c && last_digit_c;
    commit_c     = wrap_c && pending;
    accept_c     = data_valid && data_ready;
    show_c       = en && (cnt >= CNT_W'(BLANK_CYCLES));
    cur_nibble_c = disp_data[{idx, 2'b00} +: NIBBLE_W];
  end

  seven_segment u_dec (
    .nibble (cur_nibble_c),
    .seg_c  (dec_seg_c)
  );

  // Slot counter and digit index; both hold while scanning is disabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (slot_end_c) begin
        cnt <= '0;
        idx <= last_digit_c ? '0 : idx + IDX_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Pending capture on handshake, commit to display registers at frame wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pending    <= 1'b0;
      data_ready <= 1'b1;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else if (commit_c) begin
      disp_data  <= pend_data;
      disp_dp    <= pend_dp;
      disp_blank <= pend_blank;
      pending    <= 1'b0;
      data_ready <= 1'b1;
    end else if (accept_c) begin
      pend_data  <= data_in;
      pend_dp    <= dp_in;
      pend_blank <= blank_in;
      pending    <= 1'b1;
      data_ready <= 1'b0;
    end
  end

  // Registered display drive, one cycle behind index/counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      anode      <= NUM_DIGITS'(ANODE_ALL_OFF);
      segment    <= SEG_ALL_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      anode      <= NUM_DIGITS'(anode_pattern(show_c, 32'(idx)));
      segment    <= disp_blank[idx] ? SEG_ALL_OFF : dec_seg_c;
      dp         <= disp_blank[idx] ? 1'b1 : ~disp_dp[idx];
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// Directed bench for seg_display_scan_ctrl with a 4-cycle slot and 1-cycle blank.
module tb_seg_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [3:0]  anode;
  logic [6:0]  segment;
  logic        dp;
  logic        frame_done;

  int vectors = 0;
  int miscompares = 0;
  int k = 0;

  seg_display_scan_ctrl #(
    .NUM_DIGITS     (4),
    .REFRESH_CYCLES (4),
    .BLANK_CYCLES   (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .anode      (anode),
    .segment    (segment),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge, then settle; k counts edges since reset release.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = 1'b0; data_valid = 1'b0;
    data_in = '0; dp_in = '0; blank_in = '0;
    repeat (3) tick();
    reset_n = 1'b1; en = 1'b1; k = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0;
    repeat (3) tick();
    vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL reset_anode: got %h want %h", anode, 4'hF); end
    vectors++; if (segment !== 7'h7F) begin miscompares++; $display("FAIL reset_segment: got %h want %h", segment, 7'h7F); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp: got %b want 1", dp); end
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", data_ready); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    reset_n = 1'b1; en = 1'b1; k = 0;
    tick();
    vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL release_first_cycle_anode: got %h want %h", anode, 4'hF); end
    tick();
    vectors++; if (anode !== 4'hE) begin miscompares++; $display("FAIL release_first_digit_anode: got %h want %h", anode, 4'hE); end
    vectors++; if (segment !== 7'h40) begin miscompares++; $display("FAIL release_segment: got %h want %h", segment, 7'h40); end
    vectors++; if (dp !== 1'b1) begin miscompares++; $display("FAIL release_dp: got %b want 1", dp); end
  endtask

  task automatic test_scan_order();
    logic [3:0] tbl [16];
    int fd;
    tbl = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
            4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++; if (anode !== tbl[i]) begin miscompares++; $display("FAIL scan_anode k=%0d: got %h want %h", k, anode, tbl[i]); end
      vectors++; if (frame_done !== (k == 16)) begin miscompares++; $display("FAIL scan_frame_done k=%0d: got %b want %b", k, frame_done, (k == 16)); end
    end
    fd = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (frame_done === 1'b1) fd++;
    end
    vectors++; if (fd != 1) begin miscompares++; $display("FAIL scan_frame_done_count: got %0d want 1", fd); end
  endtask

  task automatic test_load_commit();
    do_reset();
    run_to(5);
    data_in = 16'h1234; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; data_in = '0;
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_after_accept: got %b want 0", data_ready); end
    run_to(14);
    vectors++; if (segment !== 7'h40) begin miscompares++; $display("FAIL load_no_tearing: got %h want %h", segment, 7'h40); end
    run_to(15);
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL load_ready_before_wrap: got %b want 0", data_ready); end
    run_to(16);
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL load_ready_after_commit: got %b want 1", data_ready); end
    run_to(18);
    vectors++; if (anode !== 4'hE) begin miscompares++; $display("FAIL load_digit0_anode: got %h want %h", anode, 4'hE); end
    vectors++; if (segment !== 7'h19) begin miscompares++; $display("FAIL load_digit0_segment: got %h want %h", segment, 7'h19); end
    run_to(30);
    vectors++; if (anode !== 4'h7) begin miscompares++; $display("FAIL load_digit3_anode: got %h want %h", anode, 4'h7); end
    vectors++; if (segment !== 7'h79) begin miscompares++; $display("FAIL load_digit3_segment: got %h want %h", segment, 7'h79); end
  endtask

  task automatic test_blank_dp();
    logic exp_dp;
    do_reset();
    data_in = 16'h1234; dp_in = 4'b0010; blank_in = 4'b1000; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;
    run_to(16);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_dp = (k >= 21 && k <= 24) ? 1'b0 : 1'b1;
      vectors++; if (dp !== exp_dp) begin miscompares++; $display("FAIL blank_dp k=%0d: got %b want %b", k, dp, exp_dp); end
      if (k == 18) begin
        vectors++; if (segment !== 7'h19) begin miscompares++; $display("FAIL blank_digit0_segment: got %h want %h", segment, 7'h19); end
      end
      if (k == 30) begin
        vectors++; if (anode !== 4'h7) begin miscompares++; $display("FAIL blank_digit3_anode: got %h want %h", anode, 4'h7); end
        vectors++; if (segment !== 7'h7F) begin miscompares++; $display("FAIL blank_digit3_segment: got %h want %h", segment, 7'h7F); end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    data_in = 16'h0001; data_valid = 1'b1;
    tick();
    data_in = 16'h0008;
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_first: got %b want 0", data_ready); end
    run_to(16);
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_commit: got %b want 1", data_ready); end
    tick();
    data_valid = 1'b0;
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_second_captured: got %b want 0", data_ready); end
    run_to(18);
    vectors++; if (segment !== 7'h79) begin miscompares++; $display("FAIL b2b_first_value_digit0: got %h want %h", segment, 7'h79); end
    run_to(30);
    vectors++; if (segment !== 7'h40) begin miscompares++; $display("FAIL b2b_first_value_digit3: got %h want %h", segment, 7'h40); end
    run_to(32);
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_second_commit: got %b want 1", data_ready); end
    run_to(34);
    vectors++; if (anode !== 4'hE) begin miscompares++; $display("FAIL b2b_second_anode: got %h want %h", anode, 4'hE); end
    vectors++; if (segment !== 7'h00) begin miscompares++; $display("FAIL b2b_second_value_digit0: got %h want %h", segment, 7'h00); end
  endtask

  task automatic test_enable();
    logic [3:0] resume_tbl [4];
    resume_tbl = '{4'hD, 4'hD, 4'hF, 4'hB};
    do_reset();
    run_to(6);
    vectors++; if (anode !== 4'hD) begin miscompares++; $display("FAIL en_before_pause: got %h want %h", anode, 4'hD); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL en_paused_anode k=%0d: got %h want %h", k, anode, 4'hF); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL en_paused_frame_done k=%0d: got %b want 0", k, frame_done); end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (anode !== resume_tbl[i]) begin miscompares++; $display("FAIL en_resume_anode k=%0d: got %h want %h", k, anode, resume_tbl[i]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_in = 16'hFFFF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; data_in = '0;
    run_to(5);
    vectors++; if (data_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_pending: got %b want 0", data_ready); end
    reset_n = 1'b0;
    tick();
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b want 1", data_ready); end
    vectors++; if (anode !== 4'hF) begin miscompares++; $display("FAIL rstmid_anode: got %h want %h", anode, 4'hF); end
    reset_n = 1'b1; k = 0;
    run_to(2);
    vectors++; if (segment !== 7'h40) begin miscompares++; $display("FAIL rstmid_restart_segment: got %h want %h", segment, 7'h40); end
    run_to(18);
    vectors++; if (segment !== 7'h40) begin miscompares++; $display("FAIL rstmid_dropped_segment: got %h want %h", segment, 7'h40); end
    vectors++; if (data_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready_after_wrap: got %b want 1", data_ready); end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_load_commit();
    test_blank_dp();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
